calc_datapath: RTL
==================

CALC_DATAPATH -- requirements
Module: calc_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits.
REQ-002 The block SHALL have port clock_i, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1; reset is synchronous and active-low.
REQ-004 The block SHALL have port a_i, input, WIDTH, operand A.
REQ-005 The block SHALL have port b_i, input, WIDTH, operand B.
REQ-006 The block SHALL have port fct_i, input, 4, operation code.
REQ-007 The block SHALL have ports a_we_i, b_we_i, fct_we_i, res_we_i, rem_we_i and done_we_i, each input, 1, register write enable from the sequencer.
REQ-008 The block SHALL have ports a_rst_i, b_rst_i, fct_rst_i, res_rst_i, rem_rst_i and done_rst_i, each input, 1, active-low synchronous clear of the matching register.
REQ-009 The block SHALL have port res_o, output, 2*WIDTH, registered result.
REQ-010 The block SHALL have port rem_o, output, WIDTH, registered remainder.
REQ-011 The block SHALL have port done_o, output, 1, registered completion flag.
REQ-012 The block SHALL have port err_o, output, 1, registered error flag, sharing the done_we_i and done_rst_i controls.

Function
REQ-013 Each internal register (a_q, b_q, fct_q, res_q, rem_q, done_q, err_q) SHALL update on the rising edge with priority reset_i low, then x_rst_i low (clear to 0), then x_we_i high (load), otherwise hold.
REQ-014 The operation SHALL use the registered operands a_q, b_q and fct_q only; a_i, b_i and fct_i SHALL have no combinational path to any output.
REQ-015 On a res_we_i edge, res_q SHALL load the ALU result; on a rem_we_i edge, rem_q SHALL load the ALU remainder; on a done_we_i edge, done_q SHALL load 1 and err_q SHALL load the ALU error bit.
REQ-016 fct 0 ADD: res = zero-extended a+b; rem=0; err=0.
REQ-017 fct 1 SUB: res = (a-b) mod 2^(2*WIDTH), operands zero-extended, so a<b gives a two's-complement wrap; rem=0; err=0.
REQ-018 fct 2 MUL: res = a*b, unsigned, full 2*WIDTH; rem=0; err=0.
REQ-019 fct 3 DIV: res = a/b, zero-extended; rem = a%b, unsigned; err=0.
REQ-020 fct 3 with b=0: res SHALL be all ones, rem SHALL equal a, and err SHALL be 1.
REQ-021 fct 4/5/6 AND/OR/XOR: res = zero-extended bitwise result; rem=0; err=0.
REQ-022 fct 7 NOT: res = zero-extended ~a; b is ignored; rem=0; err=0.
REQ-023 fct 8 SHL: res = zero-extended a shifted left by b[2:0] into the 2*WIDTH field; rem=0; err=0.
REQ-024 fct 9 SHR: res = a logically shifted right by b[2:0]; rem=0; err=0.
REQ-025 fct 10 through 15: res=0, rem=0, err=1.
REQ-026 Latency: with operands loaded at edge N (READING) and res/rem/done written at edge N+2 (WRITING), res_o, rem_o, done_o and err_o SHALL be valid from edge N+2 and held while we is low and rst is high.
REQ-027 Simultaneous we high and rst low on the same register SHALL clear that register.
REQ-028 Operand writes during the result write cycle SHALL NOT alter the result captured on that edge, because the result uses pre-edge register values.
REQ-029 done_o SHALL clear only via done_rst_i low or reset_i low, never by a new operand load.

Reset
REQ-030 On reset_i low at a rising edge, all registers and outputs SHALL become 0 on that edge: res_o=0, rem_o=0, done_o=0, err_o=0.
REQ-031 Reset asserted mid-operation, between operand load and result write, SHALL discard the loaded operands; a following result write without a new operand load SHALL compute on zero operands.
REQ-032 Outputs SHALL be undefined-free (no X) from the first edge with reset_i low.

Verification
REQ-033 The bench SHALL check: a=200, b=100, fct=0, full READING/RUNNING/WRITING sequence -> res_o=300, rem_o=0, done_o=1, err_o=0.
REQ-034 The bench SHALL check: a=5, b=9, fct=1 -> res_o=16'hFFFC, err_o=0.
REQ-035 The bench SHALL check: a=255, b=255, fct=2 -> res_o=65025; then a=100, b=7, fct=3 -> res_o=14, rem_o=2.
REQ-036 The bench SHALL check: a=42, b=0, fct=3 -> res_o=16'hFFFF, rem_o=42, err_o=1; and fct=12 -> res_o=0, err_o=1.
REQ-037 The bench SHALL check: reset_i low one cycle after operand load, then write strobes -> res_o=0, done_o=1 after the write, and all outputs 0 on the reset edge.
REQ-038 The bench SHALL check: res_we_i=1 with res_rst_i=0 on the same edge -> res_o=0; a_we_i=1 during the res write with a_i=9, previous a=3, b=4, fct=0 -> res_o=7.

Source files
------------

// File: rtl/calc_datapath.sv
// Calculator datapath: operand/opcode registers feeding a combinational ALU,
// with result, remainder and done/error registers written under sequencer control.
module calc_datapath #(
   parameter int WIDTH = 8
) (
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   input  logic [3:0]         fct_i,
   input  logic               a_we_i,
   input  logic               b_we_i,
   input  logic               fct_we_i,
   input  logic               res_we_i,
   input  logic               rem_we_i,
   input  logic               done_we_i,
   input  logic               a_rst_i,
   input  logic               b_rst_i,
   input  logic               fct_rst_i,
   input  logic               res_rst_i,
   input  logic               rem_rst_i,
   input  logic               done_rst_i,
   output logic [2*WIDTH-1:0] res_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic               done_o,
   output logic               err_o
);

   typedef struct packed {
      logic [2*WIDTH-1:0] res;
      logic [WIDTH-1:0]   rem;
      logic               err;
   } alu_out_t;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [3:0]         fct_q;
   logic [2*WIDTH-1:0] res_q;
   logic [WIDTH-1:0]   rem_q;
   logic               done_q, err_q;

   logic [2*WIDTH-1:0] a_ext, b_ext;
   alu_out_t           alu;

   assign a_ext = {{WIDTH{1'b0}}, a_q};
   assign b_ext = {{WIDTH{1'b0}}, b_q};

   // ALU sees only registered operands, so input changes never reach outputs directly
   always_comb begin
      alu = '0;
      case (fct_q)
         4'd0: alu.res = a_ext + b_ext;
         4'd1: alu.res = a_ext - b_ext;
         4'd2: alu.res = a_ext * b_ext;
         4'd3: begin
            if (b_q == '0) begin
               alu.res = '1;
               alu.rem = a_q;
               alu.err = 1'b1;
            end else begin
               alu.res = a_ext / b_ext;
               alu.rem = a_q % b_q;
            end
         end
         4'd4: alu.res = a_ext & b_ext;
         4'd5: alu.res = a_ext | b_ext;
         4'd6: alu.res = a_ext ^ b_ext;
         4'd7: alu.res = {{WIDTH{1'b0}}, ~a_q};
         4'd8: alu.res = a_ext << b_q[2:0];
         4'd9: alu.res = a_ext >> b_q[2:0];
         default: alu.err = 1'b1;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         a_q    <= '0;
         b_q    <= '0;
         fct_q  <= '0;
         res_q  <= '0;
         rem_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (!a_rst_i)        a_q   <= '0;
         else if (a_we_i)     a_q   <= a_i;
         if (!b_rst_i)        b_q   <= '0;
         else if (b_we_i)     b_q   <= b_i;
         if (!fct_rst_i)      fct_q <= '0;
         else if (fct_we_i)   fct_q <= fct_i;
         if (!res_rst_i)      res_q <= '0;
         else if (res_we_i)   res_q <= alu.res;
         if (!rem_rst_i)      rem_q <= '0;
         else if (rem_we_i)   rem_q <= alu.rem;
         // err shares the done controls so both flags always describe the same operation
         if (!done_rst_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
         end else if (done_we_i) begin
            done_q <= 1'b1;
            err_q  <= alu.err;
         end
      end
   end

   assign res_o  = res_q;
   assign rem_o  = rem_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule
